// File: rtl/data_repeater_pkg.sv
// Shared state encoding, default widths and a constant-width helper for the
// data repeater controller.
package data_repeater_pkg;

    localparam int unsigned DEF_N_BITS_IN  = 8;
    localparam int unsigned DEF_N_BITS_OUT = 16;
    localparam int unsigned DEF_MAX_REPT   = 4;
    localparam int unsigned DEF_NB_REPT    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        OUT    = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rept_mask_gen.sv
// Combinational write mask: bits ptr..ptr+rept-1 set, clipped to the output width.
module rept_mask_gen #(
    parameter int unsigned N_BITS_OUT = 16,
    parameter int unsigned NB_PTR     = 6,
    parameter int unsigned NB_REPT    = 3
) (
    input  logic [NB_PTR-1:0]     ptr_i,
    input  logic [NB_REPT-1:0]    rept_i,
    output logic [N_BITS_OUT-1:0] mask_o
);

    logic [NB_PTR:0] lo;
    logic [NB_PTR:0] hi;

    assign lo = {1'b0, ptr_i};
    assign hi = lo + (NB_PTR + 1)'(rept_i);

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < N_BITS_OUT; i++) begin
            mask_o[i] = ((NB_PTR + 1)'(i) >= lo) && ((NB_PTR + 1)'(i) < hi);
        end
    end

endmodule

// File: rtl/data_repeater_ctrl.sv
// Sequential bit repeater: expands one input bit per cycle into a registered
// output word, with valid/ready handshakes on both sides.
module data_repeater_ctrl
    import data_repeater_pkg::*;
#(
    parameter int unsigned N_BITS_IN  = DEF_N_BITS_IN,
    parameter int unsigned N_BITS_OUT = DEF_N_BITS_OUT,
    parameter int unsigned MAX_REPT   = DEF_MAX_REPT,
    parameter int unsigned NB_REPT    = DEF_NB_REPT
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [N_BITS_IN-1:0]  i_bits,
    input  logic [NB_REPT-1:0]    i_n_rept,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N_BITS_OUT-1:0] o_extended_bits,
    output logic                  o_err
);

    localparam int unsigned NB_PTR = clog2(N_BITS_OUT + MAX_REPT) + 1;
    localparam int unsigned NB_IDX = clog2(N_BITS_IN) + 1;

    state_t                state_q, state_d;
    logic [N_BITS_IN-1:0]  bits_q, bits_d;
    logic [NB_REPT-1:0]    rept_q, rept_d;
    logic                  err_pend_q, err_pend_d;
    logic [NB_IDX-1:0]     idx_q, idx_d;
    logic [NB_PTR-1:0]     ptr_q, ptr_d;
    logic [N_BITS_OUT-1:0] acc_q, acc_d;
    logic [N_BITS_OUT-1:0] ext_q, ext_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [N_BITS_OUT-1:0] mask;
    logic [N_BITS_OUT-1:0] fill;
    logic [NB_PTR-1:0]     ptr_next;
    logic                  cur_bit;
    logic                  last_step;

    rept_mask_gen #(
        .N_BITS_OUT (N_BITS_OUT),
        .NB_PTR     (NB_PTR),
        .NB_REPT    (NB_REPT)
    ) u_mask (
        .ptr_i  (ptr_q),
        .rept_i (rept_q),
        .mask_o (mask)
    );

    always_comb begin
        cur_bit = 1'b0;
        for (int unsigned i = 0; i < N_BITS_IN; i++) begin
            if (idx_q == NB_IDX'(i)) begin
                cur_bit = bits_q[i];
            end
        end
    end

    assign fill     = mask & {N_BITS_OUT{cur_bit}};
    assign ptr_next = ptr_q + NB_PTR'(rept_q);
    // A zero count finishes on the first expand edge with an empty mask (all-zero result).
    assign last_step = (rept_q == '0)
                    || (idx_q == NB_IDX'(N_BITS_IN - 1))
                    || (ptr_next >= NB_PTR'(N_BITS_OUT));

    assign o_ready         = (state_q == IDLE);
    assign o_valid         = valid_q;
    assign o_err           = err_q;
    assign o_extended_bits = ext_q;

    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        rept_d     = rept_q;
        err_pend_d = err_pend_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        valid_d    = valid_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    bits_d  = i_bits;
                    acc_d   = '0;
                    idx_d   = '0;
                    ptr_d   = '0;
                    state_d = EXPAND;
                    if (i_n_rept == '0) begin
                        rept_d     = '0;
                        err_pend_d = 1'b1;
                    end else if (i_n_rept > NB_REPT'(MAX_REPT)) begin
                        rept_d     = NB_REPT'(MAX_REPT);
                        err_pend_d = 1'b1;
                    end else begin
                        rept_d     = i_n_rept;
                        err_pend_d = 1'b0;
                    end
                end
            end
            EXPAND: begin
                acc_d = acc_q | fill;
                ptr_d = ptr_next;
                idx_d = idx_q + NB_IDX'(1);
                if (last_step) begin
                    ext_d   = acc_q | fill;
                    valid_d = 1'b1;
                    err_d   = err_pend_q;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            bits_q     <= '0;
            rept_q     <= '0;
            err_pend_q <= 1'b0;
            idx_q      <= '0;
            ptr_q      <= '0;
            acc_q      <= '0;
            ext_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            rept_q     <= rept_d;
            err_pend_q <= err_pend_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_data_repeater_ctrl.sv
// Self-checking bench for data_repeater_ctrl: directed cases, backpressure,
// mid-expand reset and randomized words against a bit-replication model.
module tb_data_repeater_ctrl;

    localparam int unsigned NIN  = 8;
    localparam int unsigned NOUT = 16;
    localparam int unsigned MAXR = 4;
    localparam int unsigned NBR  = 3;

    logic            clk;
    logic            rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [NIN-1:0]  i_bits;
    logic [NBR-1:0]  i_n_rept;
    logic            o_valid;
    logic            i_ready;
    logic [NOUT-1:0] o_ext;
    logic            o_err;

    int checks;
    int errors;

    data_repeater_ctrl #(
        .N_BITS_IN  (NIN),
        .N_BITS_OUT (NOUT),
        .MAX_REPT   (MAXR),
        .NB_REPT    (NBR)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_bits          (i_bits),
        .i_n_rept        (i_n_rept),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_extended_bits (o_ext),
        .o_err           (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit i is a copy of input bit i/r when that source exists.
    function automatic logic [NOUT-1:0] model_result(input logic [NIN-1:0] b, input int unsigned n);
        logic [NOUT-1:0] res;
        int unsigned r;
        r = (n > MAXR) ? MAXR : n;
        res = '0;
        if (r != 0) begin
            for (int unsigned i = 0; i < NOUT; i++) begin
                if (i / r < NIN) res[i] = b[i / r];
            end
        end
        return res;
    endfunction

    function automatic logic model_err(input int unsigned n);
        return (n == 0) || (n > MAXR);
    endfunction

    function automatic int model_lat(input int unsigned n);
        int unsigned r;
        int unsigned c;
        r = (n > MAXR) ? MAXR : n;
        if (r == 0) return 1;
        c = (NOUT + r - 1) / r;
        return (c < NIN) ? int'(c) : int'(NIN);
    endfunction

    // Drives one accept handshake and measures cycles until o_valid; lat=0 means timeout.
    task automatic send_word(input logic [NIN-1:0] b, input logic [NBR-1:0] n,
                             output int lat, output logic [NOUT-1:0] res, output logic err);
        @(negedge clk);
        i_bits   = b;
        i_n_rept = n;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        res = o_ext;
        err = o_err;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_bits   = '0;
        i_n_rept = '0;
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_err !== 1'b0 || o_ext !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b err=%b ext=%h, required 0 0 0000", o_valid, o_err, o_ext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: o_ready=%b, required 1", o_ready);
        end
    endtask

    task automatic test_directed();
        logic [NIN-1:0]  tb_bits [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        logic [NBR-1:0]  tb_n    [5] = '{3'd2, 3'd3, 3'd1, 3'd5, 3'd0};
        logic [NOUT-1:0] tb_res  [5] = '{16'hCC33, 16'h81C7, 16'h00A5, 16'h0F0F, 16'h0000};
        logic            tb_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int              tb_lat  [5] = '{8, 6, 8, 4, 1};
        int lat;
        logic [NOUT-1:0] res;
        logic err;
        i_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            send_word(tb_bits[t], tb_n[t], lat, res, err);
            checks++;
            if (lat != tb_lat[t]) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d, required %0d", t, lat, tb_lat[t]);
            end
            checks++;
            if (res !== tb_res[t]) begin
                errors++;
                $display("FAIL dir%0d_result: got %h, required %h", t, res, tb_res[t]);
            end
            checks++;
            if (err !== tb_err[t]) begin
                errors++;
                $display("FAIL dir%0d_err: got %b, required %b", t, err, tb_err[t]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_err !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_one_cycle: valid=%b ready=%b err=%b, required 0 1 0", t, o_valid, o_ready, o_err);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [NOUT-1:0] res;
        logic err;
        i_ready = 1'b0;
        send_word(8'hA5, 3'd2, lat, res, err);
        checks++;
        if (lat != 8 || res !== 16'hCC33) begin
            errors++;
            $display("FAIL bp_first: lat=%0d res=%h, required 8 cc33", lat, res);
        end
        i_valid  = 1'b1;
        i_bits   = 8'h3C;
        i_n_rept = 3'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_ext !== 16'hCC33 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b ext=%h ready=%b, required 1 cc33 0", c, o_valid, o_ext, o_ready);
            end
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_ext !== 16'hCC33) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b ext=%h, required 0 1 cc33", o_valid, o_ready, o_ext);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_from_idle: o_ready=%b, required 0", o_ready);
        end
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        checks++;
        if (lat != 8 || o_ext !== 16'h003C || o_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: lat=%0d ext=%h err=%b, required 8 003c 0", lat, o_ext, o_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [NOUT-1:0] res;
        logic err;
        i_ready = 1'b1;
        @(negedge clk);
        i_bits   = 8'hA5;
        i_n_rept = 3'd2;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_err !== 1'b0 || o_ext !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b err=%b ext=%h, required 0 0 0000", o_valid, o_err, o_ext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL midreset_idle%0d: valid=%b ready=%b, required 0 1", c, o_valid, o_ready);
            end
        end
        send_word(8'hA5, 3'd2, lat, res, err);
        checks++;
        if (lat != 8 || res !== 16'hCC33 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_recover: lat=%0d res=%h err=%b, required 8 cc33 0", lat, res, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat;
        int hold;
        logic [NOUT-1:0] res;
        logic err;
        logic [NIN-1:0] b;
        logic [NBR-1:0] n;
        for (int t = 0; t < 40; t++) begin
            b    = NIN'($urandom);
            n    = NBR'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            i_ready = (hold == 0);
            send_word(b, n, lat, res, err);
            checks++;
            if (lat != model_lat(n) || res !== model_result(b, n) || err !== model_err(n)) begin
                errors++;
                $display("FAIL rand%0d b=%h n=%0d: lat=%0d res=%h err=%b, required %0d %h %b",
                         t, b, n, lat, res, err, model_lat(n), model_result(b, n), model_err(n));
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                checks++;
                if (o_valid !== 1'b1 || o_ext !== model_result(b, n)) begin
                    errors++;
                    $display("FAIL rand%0d_hold%0d: valid=%b ext=%h, required 1 %h", t, h, o_valid, o_ext, model_result(b, n));
                end
            end
            i_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_drain: valid=%b err=%b ready=%b, required 0 0 1", t, o_valid, o_err, o_ready);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
